cpu_trace_buffer: RTL and testbench

Synthesizable commit-trace capture block for the single-cycle MIPS CPU. It runs beside `CPU` and samples the PC and register-file write-back port every cycle. Records are buffered in a parametrised FIFO and streamed out over a valid/ready handshake. It replaces fixed-length simulation dumps with a cycle-limited, mode-selectable hardware trace that is usable on silicon and in simulation alike.

---
 rtl/cpu_trace_buffer.sv | 119 +++++++++++
 tb/tb_cpu_trace_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture beside the single-cycle MIPS CPU: samples PC and register
// write-back each RUN cycle into a circular FIFO drained over valid/ready.
module cpu_trace_buffer #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic                     wb_en_i,
    input  logic [RADDR_W-1:0]       wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CNT_W-1:0]         out_cycle_o,
    output logic [PC_W-1:0]          out_pc_o,
    output logic                     out_wen_o,
    output logic [RADDR_W-1:0]       out_addr_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [CNT_W-1:0]   cyc;
        logic [PC_W-1:0]    pc;
        logic               wen;
        logic [RADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } rec_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic            mode_q;
    logic [CNT_W-1:0] cyc_q;
    rec_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level, level_nxt;
    logic            pop, push_req, push_ok, last_cyc;
    rec_t            head;

    always_comb begin
        pop      = (level != '0) && out_ready_i;
        push_req = (state == RUN) && (!mode_q || (wb_en_i && (wb_addr_i != '0)));
        // A full FIFO still takes the push when a slot frees up on the same edge.
        push_ok  = push_req && ((level != LW'(DEPTH)) || pop);
        last_cyc = (CYCLE_LIMIT != 0) && (cyc_q == CNT_W'(CYCLE_LIMIT - 1));
        level_nxt = level;
        unique case ({push_ok, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            cyc_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{cyc: cyc_q, pc: pc_i, wen: wb_en_i,
                                 addr: wb_addr_i, data: wb_data_i};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level_nxt;
            if (push_req && !push_ok) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
            unique case (state)
                IDLE, DONE: if (start_i) begin
                    state      <= RUN;
                    cyc_q      <= '0;
                    overflow_o <= 1'b0;
                    drop_cnt_o <= '0;
                    mode_q     <= mode_i;
                end
                RUN: begin
                    cyc_q <= cyc_q + CNT_W'(1);
                    if (last_cyc) state <= DRAIN;
                end
                DRAIN: if (level_nxt == '0) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign out_valid_o = (level != '0);
    assign out_cycle_o = head.cyc;
    assign out_pc_o    = head.pc;
    assign out_wen_o   = head.wen;
    assign out_addr_o  = head.addr;
    assign out_data_o  = head.data;
    assign level_o     = level;
    assign busy_o      = (state == RUN) || (state == DRAIN);
    assign done_o      = (state == DONE);
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: runs of each mode, overflow, full+pop,
// mid-run reset and randomised back-pressure, with a queue of expected records.
module tb_cpu_trace_buffer;
    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, wb_en, out_ready;
    logic [31:0] pc, wb_data;
    logic [4:0]  wb_addr;
    logic        out_valid, out_wen, overflow, busy, done;
    logic [15:0] out_cycle, drop_cnt;
    logic [31:0] out_pc, out_data;
    logic [4:0]  out_addr, level;

    int   n_tests = 0, n_fail = 0, n_pops = 0, busy_cnt = 0, p0;
    rec_t exp_q[$];

    cpu_trace_buffer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .pc_i(pc),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_cycle_o(out_cycle),
        .out_pc_o(out_pc), .out_wen_o(out_wen), .out_addr_o(out_addr),
        .out_data_o(out_data), .level_o(level), .overflow_o(overflow),
        .drop_cnt_o(drop_cnt), .busy_o(busy), .done_o(done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks any pop happening at the coming edge against the expected head.
    task automatic tick();
        if (out_valid && out_ready) begin
            n_pops++;
            chk("pop_q_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0)
                chk("pop_rec", 128'(rec_t'({out_cycle, out_pc, out_wen, out_addr, out_data})),
                    128'(exp_q.pop_front()));
        end
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int i, input logic en, input logic [4:0] a,
                       input logic [31:0] d, input logic push);
        rec_t r;
        pc = 32'(4 * i); wb_en = en; wb_addr = a; wb_data = d;
        r.cyc = 16'(i); r.pc = 32'(4 * i); r.wen = en; r.addr = a; r.data = d;
        if (push) exp_q.push_back(r);
        tick();
    endtask

    task automatic start_run(input logic m);
        start = 1'b1; mode = m; busy_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && !done; k++) tick();
        chk("drain_done", 128'(done), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; pc = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_level", 128'(level), 128'(0));
        chk("rst_ovf",   128'(overflow), 128'(0));
        chk("rst_drop",  128'(drop_cnt), 128'(0));
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_done",  128'(done), 128'(0));
        chk("rst_pay",   128'({out_cycle, out_pc, out_data}), 128'(0));
        rst = 1'b0;

        // Mode 0, drained every cycle: 30 records then one DRAIN cycle.
        out_ready = 1'b1;
        start_run(1'b0);
        for (int i = 0; i < 30; i++) cap(i, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("r1_drain_busy", 128'(busy), 128'(1));
        drain(5);
        chk("r1_busy_cycles", 128'(busy_cnt), 128'(31));
        chk("r1_q_empty", 128'(exp_q.size()), 128'(0));
        chk("r1_ovf", 128'(overflow), 128'(0));
        chk("r1_level", 128'(level), 128'(0));

        // Mode 1: only non-r0 writes; mode_i changes mid-run are ignored.
        p0 = n_pops;
        start_run(1'b1);
        mode = 1'b0;
        for (int i = 0; i < 30; i++) begin
            case (i)
                2:       cap(i, 1'b1, 5'd8, 32'd5, 1'b1);
                3:       cap(i, 1'b0, 5'd9, 32'd9, 1'b0);
                4:       cap(i, 1'b1, 5'd0, 32'd7, 1'b0);
                6:       cap(i, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1);
                default: cap(i, 1'b0, 5'd0, 32'd0, 1'b0);
            endcase
        end
        drain(5);
        chk("r2_pop_count", 128'(n_pops - p0), 128'(2));

        // Overflow: no consumer for the whole run.
        out_ready = 1'b0;
        start_run(1'b0);
        chk("r3_start_ovf_clr", 128'(overflow), 128'(0));
        for (int i = 0; i < 30; i++) cap(i, 1'b0, 5'd0, 32'(i), i < 16);
        chk("r3_level", 128'(level), 128'(16));
        chk("r3_ovf", 128'(overflow), 128'(1));
        chk("r3_drop", 128'(drop_cnt), 128'(14));
        chk("r3_head", 128'(out_cycle), 128'(0));
        out_ready = 1'b1;
        drain(40);
        chk("r3_q_empty", 128'(exp_q.size()), 128'(0));
        chk("r3_drop_done", 128'(drop_cnt), 128'(14));

        // Full FIFO with a pop on the same edge as a push.
        out_ready = 1'b0;
        start_run(1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i == 20) begin
                chk("r4_pre_level", 128'(level), 128'(16));
                chk("r4_pre_drop", 128'(drop_cnt), 128'(4));
                out_ready = 1'b1;
            end
            cap(i, 1'b0, 5'd0, 32'(i), (i < 16) || (i == 20));
            if (i == 20) begin
                out_ready = 1'b0;
                chk("r4_full_pop_level", 128'(level), 128'(16));
                chk("r4_full_pop_drop", 128'(drop_cnt), 128'(4));
            end
        end
        chk("r4_drop", 128'(drop_cnt), 128'(13));
        out_ready = 1'b1;
        drain(40);
        chk("r4_q_empty", 128'(exp_q.size()), 128'(0));

        // Reset at capture cycle 10 with 5 records buffered.
        out_ready = 1'b0;
        start_run(1'b1);
        for (int i = 0; i < 10; i++) cap(i, (i % 2) == 0, 5'd3, 32'(i), 1'b0);
        chk("r5_level_pre", 128'(level), 128'(5));
        rst = 1'b1;
        tick();
        chk("r5_level", 128'(level), 128'(0));
        chk("r5_valid", 128'(out_valid), 128'(0));
        chk("r5_busy", 128'(busy), 128'(0));
        chk("r5_done", 128'(done), 128'(0));
        chk("r5_pay", 128'(out_cycle), 128'(0));
        start = 1'b1;
        tick();
        chk("r5_rst_wins", 128'({busy, done}), 128'(0));
        rst = 1'b0; start = 1'b0;

        // Random back-pressure over four runs: 40 records, pointers wrap twice.
        p0 = n_pops;
        for (int r = 0; r < 4; r++) begin
            out_ready = ($urandom_range(0, 99) < 40);
            start_run(1'b1);
            for (int i = 0; i < 30; i++) begin
                out_ready = ($urandom_range(0, 99) < 40);
                cap(i, (i % 3) == 0, 5'((i % 31) + 1), $urandom, (i % 3) == 0);
            end
            for (int k = 0; k < 300 && !done; k++) begin
                out_ready = ($urandom_range(0, 99) < 40);
                tick();
            end
            chk("r6_done", 128'(done), 128'(1));
            chk("r6_q_empty", 128'(exp_q.size()), 128'(0));
            chk("r6_ovf", 128'(overflow), 128'(0));
        end
        chk("r6_pop_count", 128'(n_pops - p0), 128'(40));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
